// File: rtl/byte_word_packer.sv
// ============================================================================
// byte_word_packer
// Packs a valid/ready byte stream into 16-bit words with a 2-bit lane enable.
// A packet that ends on an odd byte produces a partial word with one lane set.
// Optional macro: PACKER_BIG_ENDIAN_EN (first byte goes to d[15:8]).
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_word_packer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] d,
  output logic [1:0]  byteena
);

  typedef enum logic [0:0] {
    LOW  = 1'b0,
    HIGH = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  hold;
  logic [7:0]  hold_next;
  logic        word_load;
  logic [15:0] word_d;
  logic [1:0]  word_be;
  logic        accept;

  // The output register can take a new word whenever it is empty or being
  // drained this cycle, so ready never looks at in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Pack-state next-state logic and completed-word formation.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    word_load  = 1'b0;
    word_d     = 16'h0000;
    word_be    = 2'b00;
    case (state)
      LOW: begin
        if (accept) begin
          if (in_last) begin
            word_load = 1'b1;
`ifdef PACKER_BIG_ENDIAN_EN
            word_d    = {in_data, 8'h00};
            word_be   = 2'b10;
`else
            word_d    = {8'h00, in_data};
            word_be   = 2'b01;
`endif
          end else begin
            hold_next  = in_data;
            state_next = HIGH;
          end
        end
      end
      HIGH: begin
        if (accept) begin
          word_load  = 1'b1;
`ifdef PACKER_BIG_ENDIAN_EN
          word_d     = {hold, in_data};
`else
          word_d     = {in_data, hold};
`endif
          word_be    = 2'b11;
          state_next = LOW;
        end
      end
      default: begin
        state_next = LOW;
      end
    endcase
  end

  // Pack state and first-byte hold register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= LOW;
      hold  <= 8'h00;
    end else begin
      state <= state_next;
      hold  <= hold_next;
    end
  end

  // Output stage: a completing word overrides a drain so there is no bubble;
  // data and lane enables keep their last value when nothing is loaded.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      d         <= 16'h0000;
      byteena   <= 2'b00;
    end else if (word_load) begin
      out_valid <= 1'b1;
      d         <= word_d;
      byteena   <= word_be;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/byte_word_packer.md
# byte_word_packer

Source side of the 16-bit byte-enabled register interface: packs a valid/ready byte stream into 16-bit words with a 2-bit byte-lane enable (`d`, `byteena`) for the byte-enabled 16-bit DFF register and its consumers. It holds the first byte of each pair, emits a full word with both lanes enabled, and emits a partial word with one lane enabled when the stream ends on an odd byte. Output is a registered valid/ready stage with single-byte-per-cycle throughput.

## Interface
- No parameters; data widths fixed at 8 in, 16 out.
- `clk`  in  1  sole clock, all logic on rising edge.
- `resetn`  in  1  reset is synchronous and active-low.
- `in_valid`  in  1  input byte present.
- `in_ready`  out  1  packer accepts byte this cycle; transfer when `in_valid && in_ready`.
- `in_data`  in  8  input byte.
- `in_last`  in  1  byte is last of its packet; qualified by `in_valid`.
- `out_valid`  out  1  word on `d`/`byteena` valid.
- `out_ready`  in  1  downstream takes word this cycle; transfer when `out_valid && out_ready`.
- `d`  out  16  packed word; disabled lane is 8'h00.
- `byteena`  out  2  lane enables; bit 0 = d[7:0], bit 1 = d[15:8].

## Operation
- Two pack states: LOW (no byte held), HIGH (first byte held in 8-bit hold register).
- `in_ready = !out_valid || out_ready` (combinational, never depends on `in_valid`).
- Accept in LOW, `in_last=0`: store byte in hold register -> HIGH; output register unchanged.
- Accept in LOW, `in_last=1`: load output with first-lane word (d = {8'h00, byte}, byteena = 2'b01), `out_valid<=1`, stay LOW.
- Accept in HIGH (any `in_last`): load output with d = {byte, held}, byteena = 2'b11, `out_valid<=1` -> LOW.
- Output register: loads only on word completion; otherwise, if `out_ready`, `out_valid<=0`; `d`/`byteena` hold their last value.
- `d`, `byteena` stable while `out_valid && !out_ready`.
- No words emitted with byteena 2'b00 or 2'b10 (default build).

## Timing
- Reset (`resetn=0` at rising edge): state LOW, hold register 0, `out_valid=0`, `d=16'h0000`, `byteena=2'b00`; `in_ready` reads 1 during and after reset.
- Reset mid-operation discards held byte and any pending word; no partial flush.
- Latency: word visible on `out_valid` the cycle after the completing byte is accepted.
- Simultaneous output drain and word completion in same cycle: new word replaces drained one, `out_valid` stays 1, no bubble.
- Sustained `in_valid=1`, `out_ready=1`: one byte accepted every cycle, one word every two cycles.
- Backpressure: `out_valid && !out_ready` forces `in_ready=0` in both states, including LOW with `in_last=0` (no hidden buffering).

## Configuration
- `PACKER_BIG_ENDIAN_EN` undefined: first byte to d[7:0]; partial word is {8'h00, byte}, byteena 2'b01; full word {second, first}.
- `PACKER_BIG_ENDIAN_EN` defined: first byte to d[15:8]; partial word is {byte, 8'h00}, byteena 2'b10; full word {first, second}. All handshake and timing rules unchanged.

## Test plan
- Reset: hold `resetn=0` 3 cycles with `in_valid=1` -> `out_valid=0`, `d=0`, `byteena=0`; release, send 8'hCD, 8'hAB -> one word d=16'hABCD, byteena=2'b11.
- Odd packet: send 8'h12, 8'h34, 8'h56(last) with `out_ready=1` -> words 16'h3412/2'b11 then 16'h0056/2'b01; big-endian build: 16'h1234/2'b11 then 16'h5600/2'b10.
- Backpressure: `out_ready=0` after one full word -> `in_ready=0`, `d`/`byteena` unchanged for 5 cycles; raise `out_ready` -> word taken, next bytes accepted, no loss or duplication.
- Reset mid-pair: accept 8'hEE (HIGH), pulse `resetn=0` one cycle, then send 8'h01, 8'h02 -> only word 16'h0201/2'b11; 8'hEE never appears.
- Streaming: 400 random bytes, random `in_last` (~1/8), random `in_valid`/`out_ready` -> output matches scoreboard word-for-word including byteena; throughput 1 byte/cycle when both always high.
